// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b, one bit per clock LSB-first,
// with a single borrow flip-flop, start/done handshake and unsigned/signed flags.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res_sr;
  logic          br;
  logic          a_msb;
  logic          b_msb;
  logic [CW-1:0] cnt;

  logic          d_bit;
  logic          br_next;
  logic [N-1:0]  res_next;
  logic          last_bit;

  // Full-adder equations with the subtrahend inverted and carry recast as borrow.
  function automatic logic sub_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  // Signed overflow: operands of opposite sign and result sign differs from minuend.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sd);
    return (sa != sb) && (sd != sa);
  endfunction

  always_comb begin
    d_bit    = sub_diff(a_sr[0], b_sr[0], br);
    br_next  = sub_borrow(a_sr[0], b_sr[0], br);
    res_next = {d_bit, res_sr[N-1:1]};
    last_bit = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= a[N-1];
            b_msb <= b[N-1];
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            diff   <= res_next;
            borrow <= br_next;
            ovf    <= sub_ovf(a_msb, b_msb, res_next[N-1]);
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: N=8 handshake/timing vectors plus an
// exhaustive N=4 sweep against an arithmetic reference.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8, ovf8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4, ovf4;
  logic [3:0] diff4;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
  );

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 operation: start for one edge, then watch N+4 edges.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     output int lat, output int busy_cyc, output int done_cyc);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0; busy_cyc = busy8 ? 1 : 0; done_cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (busy8) busy_cyc++;
      if (done8) begin
        done_cyc++;
        if (lat == 0) lat = k;
      end
    end
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv);
    int sa, sb, sd;
    logic got;
    logic [3:0] exp_d;
    a4 = av; b4 = bv; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (done4) got = 1'b1;
    end
    sa = (av >= 8) ? int'(av) - 16 : int'(av);
    sb = (bv >= 8) ? int'(bv) - 16 : int'(bv);
    sd = sa - sb;
    exp_d = 4'(av - bv);
    check("n4_done", {31'd0, got}, 32'd1);
    check($sformatf("n4_diff_%0h_%0h", av, bv), {28'd0, diff4}, {28'd0, exp_d});
    check($sformatf("n4_borrow_%0h_%0h", av, bv), {31'd0, borrow4}, {31'd0, av < bv});
    check($sformatf("n4_ovf_%0h_%0h", av, bv), {31'd0, ovf4}, {31'd0, (sd > 7) || (sd < -8)});
    tick();
  endtask

  initial begin
    int lat, bc, dc, ndone, last_e, gap_ok, gaps;
    logic got;

    // Reset state
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_diff", {24'd0, diff8}, 32'd0);
    check("rst_borrow", {31'd0, borrow8}, 32'd0);
    check("rst_ovf", {31'd0, ovf8}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 5 - 3
    op8(8'd5, 8'd3, lat, bc, dc);
    check("op1_latency", lat, 8);
    check("op1_busy_cycles", bc, 9);
    check("op1_done_cycles", dc, 1);
    check("op1_diff", {24'd0, diff8}, 32'h02);
    check("op1_borrow", {31'd0, borrow8}, 32'd0);
    check("op1_ovf", {31'd0, ovf8}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("hold_diff", {24'd0, diff8}, 32'h02);
    check("hold_busy", {31'd0, busy8}, 32'd0);

    op8(8'd3, 8'd5, lat, bc, dc);
    check("op2_diff", {24'd0, diff8}, 32'hFE);
    check("op2_borrow", {31'd0, borrow8}, 32'd1);
    check("op2_ovf", {31'd0, ovf8}, 32'd0);

    op8(8'h80, 8'h01, lat, bc, dc);
    check("op3_diff", {24'd0, diff8}, 32'h7F);
    check("op3_borrow", {31'd0, borrow8}, 32'd0);
    check("op3_ovf", {31'd0, ovf8}, 32'd1);

    op8(8'h7F, 8'hFF, lat, bc, dc);
    check("op4_diff", {24'd0, diff8}, 32'h80);
    check("op4_borrow", {31'd0, borrow8}, 32'd1);
    check("op4_ovf", {31'd0, ovf8}, 32'd1);

    op8(8'h00, 8'h00, lat, bc, dc);
    check("op5_diff", {24'd0, diff8}, 32'h00);
    check("op5_borrow", {31'd0, borrow8}, 32'd0);
    check("op5_ovf", {31'd0, ovf8}, 32'd0);

    op8(8'hFF, 8'hFF, lat, bc, dc);
    check("op6_diff", {24'd0, diff8}, 32'h00);
    check("op6_borrow", {31'd0, borrow8}, 32'd0);
    check("op6_ovf", {31'd0, ovf8}, 32'd0);

    // start pulsed mid-SHIFT with new operands must be ignored
    a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick();
      if (done8) got = 1'b1;
    end
    check("ign_done", {31'd0, got}, 32'd1);
    check("ign_diff", {24'd0, diff8}, 32'h05);
    check("ign_borrow", {31'd0, borrow8}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) ndone++;
    end
    check("ign_no_second_op", ndone, 0);

    // Asynchronous reset during the 4th SHIFT cycle
    a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    check("abort_diff", {24'd0, diff8}, 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0; bc = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) ndone++;
      if (busy8) bc++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_stays_idle", bc, 0);

    op8(8'd10, 8'd7, lat, bc, dc);
    check("post_abort_latency", lat, 8);
    check("post_abort_diff", {24'd0, diff8}, 32'h03);

    // start held high: one result every N+2 edges
    a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
    last_e = -1; gaps = 0; gap_ok = 0; ndone = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (done8) begin
        ndone++;
        if (last_e >= 0) begin
          gaps++;
          if (k - last_e == 10) gap_ok++;
        end
        last_e = k;
      end
    end
    start8 = 1'b0;
    check("cont_done_count", ndone, 4);
    check("cont_gaps_10", gap_ok, 3);
    for (int k = 0; k < 12 && busy8; k++) tick();
    check("cont_idle", {31'd0, busy8}, 32'd0);

    // Exhaustive N=4 sweep
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op4(4'(i), 4'(j));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing A − B LSB-first, one bit per clock, with a single borrow flip-flop and a start/done handshake. It is the inverse operation of the team's ripple full-adder datapath. It uses the same full-adder bit equations with the B operand inverted and the carry replaced by a borrow. It sits beside the adder blocks as a low-area arithmetic unit for the lab ALU.

## Interface
- N, default 8: operand and result width in bits (N ≥ 2).

- clk  in  1  rising-edge system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- a  in  N  minuend; latched on the accepted start edge
- b  in  N  subtrahend; latched on the accepted start edge
- busy  out  1  high while an operation is in progress (SHIFT or DONE)
- done  out  1  one-cycle pulse; diff, borrow and ovf are valid in that cycle and afterwards
- diff  out  N  A − B modulo 2^N
- borrow  out  1  unsigned borrow out: 1 when A < B unsigned
- ovf  out  1  signed (two's-complement) overflow of A − B

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on a clock edge with start=1. That edge latches a and b into shift registers, clears the borrow register br and the bit counter, and latches a[N-1] and b[N-1].
  - SHIFT: each edge processes bit i = a_sr[0], b_sr[0]:
    - d = a_sr[0] ^ b_sr[0] ^ br
    - br ← (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br)
    - d is shifted into the result register from the MSB side; a_sr and b_sr shift right; the counter increments.
  - On the Nth SHIFT edge, transition to DONE and update outputs:
    - diff ← completed result
    - borrow ← final br
    - ovf ← (aN ≠ bN) & (diff[N-1] ≠ aN), where aN and bN are the latched sign bits
  - DONE → IDLE unconditionally on the next edge.
- start is ignored in SHIFT and DONE. New a and b values presented then have no effect.
- diff, borrow and ovf hold their last values until the next operation completes. They are not cleared when a new operation starts.
- Counter width is $clog2(N+1). The counter does not wrap within an operation.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0. Internal shift registers, br and counter are cleared.
- Let E0 be the edge that accepts start.
  - busy rises after E0 and stays high through the DONE cycle.
  - SHIFT occupies edges E0+1 … E0+N. The outputs update at E0+N.
  - done=1 in the single cycle between E0+N and E0+N+1; it falls at E0+N+1 along with busy.
- Latency: result valid N cycles after the accepting edge.
- Throughput: start held continuously high gives one operation every N+2 edges. The IDLE cycle after DONE accepts the next start.
- Reset asserted mid-SHIFT or in DONE aborts the operation: no done pulse, outputs forced to 0. After release, the block waits in IDLE for a fresh start.
- start and rst asserted together: reset wins.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- N=8, reset, then a=5, b=3, start for 1 cycle → done pulse exactly 8 cycles after the accepting edge; diff=0x02, borrow=0, ovf=0; busy high for 9 cycles.
- a=3, b=5 → diff=0xFE, borrow=1, ovf=0. Then a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, borrow=1, ovf=1.
- a=0x00, b=0x00 and a=0xFF, b=0xFF → diff=0x00, borrow=0, ovf=0 in both cases. Also, after the first op's done pulse, diff holds its value while the block sits in IDLE for 5 cycles.
- During SHIFT, pulse start with a=0x11, b=0x22 → ignored; the original op (a=9, b=4) completes with diff=0x05. start held high continuously → done pulses exactly every 10 cycles.
- Assert rst at the 4th SHIFT cycle → busy=0, done=0, diff=0 immediately, with no later done pulse. After release, start with a=10, b=7 → diff=0x03.
- Exhaustive N=4 sweep over all 256 (a,b) pairs, compared against a reference model → diff, borrow and ovf match for every pair.
